// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-cache memory port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D_WRITE = 2'd1,
    D_READ  = 2'd2,
    I_READ  = 2'd3
  } mem_arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } requester_t;

  localparam int LINE_BEATS = 4;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin pick; the history register moves only when
// the chosen request is actually accepted downstream.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_icache,
  input  logic       req_dcache,
  input  logic       accept,
  output requester_t grant,
  output logic       valid
);

  requester_t last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ICACHE;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

  always_comb begin
    valid = req_icache | req_dcache;
    grant = ICACHE;
    if (req_icache && req_dcache) begin
      grant = (last_grant == ICACHE) ? DCACHE : ICACHE;
    end else if (req_dcache) begin
      grant = DCACHE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one burst memory port between icache (read) and dcache (read/write),
// granting whole line transactions and steering read beats to their owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = LINE_BEATS
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W-1:0] i_raddr,
  output logic              i_rvalid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] d_raddr,
  output logic              d_rvalid,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [ADDR_W-1:0] m_raddr,
  input  logic              m_rvalid,
  output logic              busy
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OFF_W = $clog2(BURST_LEN * DATA_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  // Handshake: a request or write beat transfers in any cycle where the
  // driver's request/m_write and m_ready are both high; *_ready reflects
  // that transfer back to the owning cache in the same cycle. Read beats
  // have no back-pressure: m_rvalid is consumed unconditionally.

  mem_arb_state_t   state;
  logic [CNT_W-1:0] beat_cnt;
  requester_t       grant;
  logic             req_valid;
  logic             accept;
  logic [ADDR_W-1:0] i_line;
  logic [ADDR_W-1:0] d_line;
  logic             unused_offset;

  assign i_line = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign d_line = {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign unused_offset = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

  assign accept = (state == IDLE) && req_valid && m_ready && !rst;
  assign busy   = (state != IDLE);

  rr_arbiter2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .req_icache (i_read),
    .req_dcache (d_read | d_write),
    .accept     (accept),
    .grant      (grant),
    .valid      (req_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (grant == ICACHE) begin
              state    <= I_READ;
              beat_cnt <= '0;
            end else if (d_write) begin
              state    <= D_WRITE;
              beat_cnt <= CNT_W'(1);
            end else begin
              state    <= D_READ;
              beat_cnt <= '0;
            end
          end
        end
        D_WRITE: begin
          if (m_ready) begin
            if (beat_cnt == LAST_BEAT) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        D_READ, I_READ: begin
          if (m_rvalid) begin
            if (beat_cnt == LAST_BEAT) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs are held quiet during reset so an abandoned burst never leaks.
  always_comb begin
    i_ready  = 1'b0;
    i_rdata  = '0;
    i_raddr  = '0;
    i_rvalid = 1'b0;
    d_ready  = 1'b0;
    d_rdata  = '0;
    d_raddr  = '0;
    d_rvalid = 1'b0;
    m_addr   = '0;
    m_read   = 1'b0;
    m_write  = 1'b0;
    m_wdata  = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (grant == ICACHE) begin
              m_read  = 1'b1;
              m_addr  = i_line;
              i_ready = m_ready;
            end else begin
              m_addr  = d_line;
              d_ready = m_ready;
              if (d_write) begin
                m_write = 1'b1;
                m_wdata = d_wdata;
              end else begin
                m_read = 1'b1;
              end
            end
          end
        end
        D_WRITE: begin
          m_write = 1'b1;
          m_addr  = d_line;
          m_wdata = d_wdata;
          d_ready = m_ready;
        end
        D_READ: begin
          d_rvalid = m_rvalid;
          d_rdata  = m_rdata;
          d_raddr  = m_raddr;
        end
        I_READ: begin
          i_rvalid = m_rvalid;
          i_rdata  = m_rdata;
          i_raddr  = m_raddr;
        end
        default: ;
      endcase
    end
  end

  a_no_rd_wr: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
    else $error("dcache asserted read and write together");

  a_wr_held: assert property (@(posedge clk) disable iff (rst) (state == D_WRITE) |-> d_write)
    else $error("dcache dropped d_write mid-burst");

  a_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
      m_rvalid |-> (state == D_READ || state == I_READ))
    else $warning("stray m_rvalid ignored outside a read burst");

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, lone reads, round-robin contention,
// stalled write-back, address alignment, stray beats and mid-burst reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr;
  logic        i_read;
  logic        i_ready;
  logic [63:0] i_rdata;
  logic [31:0] i_raddr;
  logic        i_rvalid;
  logic [31:0] d_addr;
  logic        d_read;
  logic        d_write;
  logic [63:0] d_wdata;
  logic        d_ready;
  logic [63:0] d_rdata;
  logic [31:0] d_raddr;
  logic        d_rvalid;
  logic [31:0] m_addr;
  logic        m_read;
  logic        m_write;
  logic [63:0] m_wdata;
  logic        m_ready;
  logic [63:0] m_rdata;
  logic [31:0] m_raddr;
  logic        m_rvalid;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_ready(i_ready),
    .i_rdata(i_rdata), .i_raddr(i_raddr), .i_rvalid(i_rvalid),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_raddr(d_raddr), .d_rvalid(d_rvalid),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_raddr(m_raddr), .m_rvalid(m_rvalid),
    .busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Feeds one 4-beat read return and checks it lands only at the owner.
  task automatic feed_beats(input logic own_d, input logic [31:0] raddr, input logic [63:0] base);
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = base + 64'(b);
      m_raddr  = raddr;
      #1;
      check("rd_no_ready", {62'd0, i_ready, d_ready}, 64'd0);
      check("rd_m_read", m_read, 1'b0);
      check("rd_busy", busy, 1'b1);
      if (own_d) begin
        check("d_rvalid", d_rvalid, 1'b1);
        check("d_rdata", d_rdata, base + 64'(b));
        check("d_raddr", d_raddr, raddr);
        check("i_rvalid_off", i_rvalid, 1'b0);
        check("i_rdata_zero", i_rdata, 64'd0);
      end else begin
        check("i_rvalid", i_rvalid, 1'b1);
        check("i_rdata", i_rdata, base + 64'(b));
        check("i_raddr", i_raddr, raddr);
        check("d_rvalid_off", d_rvalid, 1'b0);
        check("d_rdata_zero", d_rdata, 64'd0);
      end
      tick();
    end
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_raddr  = '0;
    #1;
    check("busy_after_burst", busy, 1'b0);
  endtask

  initial begin
    logic        pat[6];
    logic [63:0] beats[4];
    int          idx;
    int          hs;
    logic [63:0] exp_beat;

    pat   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    beats = '{64'h11, 64'h22, 64'h33, 64'h44};

    rst = 1'b1; i_addr = '0; i_read = 1'b1; d_addr = '0; d_read = 1'b0;
    d_write = 1'b0; d_wdata = '0; m_ready = 1'b1; m_rdata = '0; m_raddr = '0;
    m_rvalid = 1'b0;
    tick(); tick();
    check("rst_i_ready", i_ready, 1'b0);
    check("rst_m_read", m_read, 1'b0);
    i_read = 1'b0;
    rst = 1'b0;
    tick();
    check("rst_state", dut.state, IDLE);
    check("rst_busy", busy, 1'b0);
    check("rst_last_grant", dut.u_rr.last_grant, ICACHE);
    check("rst_m_addr", m_addr, 64'd0);

    // Lone icache read
    i_read = 1'b1; i_addr = 32'h0000_1040; m_ready = 1'b1;
    #1;
    check("lone_m_read", m_read, 1'b1);
    check("lone_m_addr", m_addr, 32'h0000_1040);
    check("lone_i_ready", i_ready, 1'b1);
    check("lone_d_ready", d_ready, 1'b0);
    tick();
    i_read = 1'b0;
    feed_beats(1'b0, 32'h0000_1040, 64'hA0);

    // Contention after an icache grant goes to dcache, then icache
    i_read = 1'b1; i_addr = 32'h0000_1080; d_read = 1'b1; d_addr = 32'h0000_3000;
    #1;
    check("rr1_d_ready", d_ready, 1'b1);
    check("rr1_i_ready", i_ready, 1'b0);
    check("rr1_m_addr", m_addr, 32'h0000_3000);
    check("rr1_m_read", m_read, 1'b1);
    tick();
    d_read = 1'b0;
    feed_beats(1'b1, 32'h0000_3000, 64'hB0);
    check("rr2_i_ready", i_ready, 1'b1);
    check("rr2_m_addr", m_addr, 32'h0000_1080);
    tick();
    i_read = 1'b0;
    feed_beats(1'b0, 32'h0000_1080, 64'hC0);
    i_read = 1'b1; d_read = 1'b1; d_addr = 32'h0000_3100;
    #1;
    check("rr3_d_ready", d_ready, 1'b1);
    check("rr3_i_ready", i_ready, 1'b0);
    tick();
    i_read = 1'b0; d_read = 1'b0;
    feed_beats(1'b1, 32'h0000_3100, 64'hD0);

    // Write-back with m_ready stalls, icache waiting behind it
    for (int k = 0; k < 4; k++) exp_q.push_back(beats[k]);
    idx = 0; hs = 0;
    d_write = 1'b1; d_addr = 32'h8000_0020; i_addr = 32'h0000_1100;
    for (int k = 0; k < 6; k++) begin
      m_ready = pat[k];
      d_wdata = beats[idx];
      if (k == 1) i_read = 1'b1;
      #1;
      check("wr_m_write", m_write, 1'b1);
      check("wr_m_addr", m_addr, 32'h8000_0020);
      check("wr_d_ready", d_ready, pat[k]);
      check("wr_i_ready", i_ready, 1'b0);
      if (m_write && m_ready) begin
        exp_beat = exp_q.pop_front();
        check("wr_m_wdata", m_wdata, exp_beat);
        hs++;
        if (idx < 3) idx++;
      end
      tick();
    end
    d_write = 1'b0; m_ready = 1'b1;
    #1;
    check("wr_handshakes", 64'(hs), 64'd4);
    check("wr_queue_empty", 64'(exp_q.size()), 64'd0);
    check("wr_done_busy", busy, 1'b0);
    check("wr_i_granted", i_ready, 1'b1);
    check("wr_i_addr", m_addr, 32'h0000_1100);
    tick();
    i_read = 1'b0;
    feed_beats(1'b0, 32'h0000_1100, 64'hE0);

    // Misaligned dcache read, first stalled by m_ready
    d_read = 1'b1; d_addr = 32'h0000_203C; m_ready = 1'b0;
    #1;
    check("stall_m_read", m_read, 1'b1);
    check("stall_d_ready", d_ready, 1'b0);
    tick();
    check("stall_state", dut.state, IDLE);
    m_ready = 1'b1;
    #1;
    check("align_m_addr", m_addr, 32'h0000_2020);
    check("align_d_ready", d_ready, 1'b1);
    tick();
    d_read = 1'b0;
    feed_beats(1'b1, 32'h0000_2020, 64'hF0);

    // Stray read beat while idle
    m_rvalid = 1'b1; m_rdata = 64'hDEAD; m_raddr = 32'h0000_9000;
    #1;
    check("stray_i_rvalid", i_rvalid, 1'b0);
    check("stray_d_rvalid", d_rvalid, 1'b0);
    check("stray_i_rdata", i_rdata, 64'd0);
    tick();
    m_rvalid = 1'b0; m_rdata = '0; m_raddr = '0;
    #1;
    check("stray_state", dut.state, IDLE);
    check("stray_busy", busy, 1'b0);

    // Reset two beats into a write-back
    d_write = 1'b1; d_addr = 32'h0000_4000; d_wdata = 64'h55; m_ready = 1'b1;
    tick();
    d_wdata = 64'h66;
    tick();
    check("mid_state", dut.state, D_WRITE);
    rst = 1'b1; d_write = 1'b0;
    #1;
    check("rst_gate_m_write", m_write, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_state", dut.state, IDLE);
    check("post_rst_m_write", m_write, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_cnt", 64'(dut.beat_cnt), 64'd0);
    i_read = 1'b1; i_addr = 32'h0000_5000;
    #1;
    check("post_rst_i_ready", i_ready, 1'b1);
    check("post_rst_m_read", m_read, 1'b1);
    check("post_rst_m_addr", m_addr, 32'h0000_5000);
    tick();
    i_read = 1'b0;
    feed_beats(1'b0, 32'h0000_5000, 64'h70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
